// File: rtl/vol_arb_pkg.sv
// Shared types and defaults for the volume arbiter.
// Phase states, default sizing and a width helper used by the arbiter and its round-robin pickers.
package vol_arb_pkg;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FULL_HOLD  = 2'd1,
        DRAIN      = 2'd2,
        EMPTY_HOLD = 2'd3
    } state_t;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_CAP      = 750;
    localparam int unsigned DEF_CBITS    = 10;
    localparam int unsigned DEF_IDLE_MAX = 15;

    // Index width that stays at least one bit wide for tiny requester counts.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vol_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above i_ptr, wrapping modulo N.
// Produces a one-hot grant, a valid flag and the winning index.
module rr_pick
    import vol_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    int unsigned w_j;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_j]) begin
                o_valid    = 1'b1;
                o_idx      = IW'(w_j);
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vol_arbiter.sv
// Shares one bounded volume counter between load and store requesters, alternating FILL and DRAIN
// phases with round-robin grants, an idle timeout to force a phase switch, and a pulse per fill.
module vol_arbiter
    import vol_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned CAP      = DEF_CAP,
    parameter int unsigned CBITS    = DEF_CBITS,
    parameter int unsigned IDLE_MAX = DEF_IDLE_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] ld_req,
    input  logic [N_REQ-1:0] st_req,
    output logic [N_REQ-1:0] ld_gnt,
    output logic [N_REQ-1:0] st_gnt,
    output logic [CBITS-1:0] vol,
    output logic             full,
    output logic             empty,
    output logic             sig
);

    localparam int unsigned IW    = clog2_min1(N_REQ);
    localparam int unsigned IBITS = $clog2(IDLE_MAX + 1);
    localparam logic [CBITS-1:0] L_CAP  = CBITS'(CAP);
    localparam logic [IBITS-1:0] L_IMAX = IBITS'(IDLE_MAX);
    localparam logic [IW-1:0]    L_LAST = IW'(N_REQ - 1);

    state_t             r_state, w_state_nx;
    logic [CBITS-1:0]   r_vol, w_vol_nx;
    logic [N_REQ-1:0]   r_ld_gnt, w_ld_gnt_nx;
    logic [N_REQ-1:0]   r_st_gnt, w_st_gnt_nx;
    logic               r_sig, w_sig_nx;
    logic [IW-1:0]      r_ld_ptr, w_ld_ptr_nx;
    logic [IW-1:0]      r_st_ptr, w_st_ptr_nx;
    logic [IBITS-1:0]   r_idle, w_idle_nx, w_idle_inc;

    logic [N_REQ-1:0]   w_ld_pick, w_st_pick;
    logic               w_ld_valid, w_st_valid;
    logic [IW-1:0]      w_ld_idx, w_st_idx;

    rr_pick #(.N(N_REQ)) u_ld_pick (
        .i_req   (ld_req),
        .i_ptr   (r_ld_ptr),
        .o_gnt   (w_ld_pick),
        .o_valid (w_ld_valid),
        .o_idx   (w_ld_idx)
    );

    rr_pick #(.N(N_REQ)) u_st_pick (
        .i_req   (st_req),
        .i_ptr   (r_st_ptr),
        .o_gnt   (w_st_pick),
        .o_valid (w_st_valid),
        .o_idx   (w_st_idx)
    );

    assign w_idle_inc = (r_idle >= L_IMAX) ? L_IMAX : r_idle + IBITS'(1);

    always_comb begin
        w_state_nx  = r_state;
        w_vol_nx    = r_vol;
        w_ld_gnt_nx = '0;
        w_st_gnt_nx = '0;
        w_ld_ptr_nx = r_ld_ptr;
        w_st_ptr_nx = r_st_ptr;
        w_idle_nx   = r_idle;
        // The pulse is emitted on the edge that leaves FULL_HOLD, so it lands one cycle after vol hits CAP.
        w_sig_nx    = (r_state == FULL_HOLD);
        case (r_state)
            FILL: begin
                if (r_vol == L_CAP) begin
                    w_state_nx = FULL_HOLD;
                    w_idle_nx  = '0;
                end else if (w_ld_valid) begin
                    w_ld_gnt_nx = w_ld_pick;
                    w_vol_nx    = r_vol + CBITS'(1);
                    w_ld_ptr_nx = (w_ld_idx == L_LAST) ? '0 : w_ld_idx + IW'(1);
                    w_idle_nx   = '0;
                    if (r_vol + CBITS'(1) == L_CAP) w_state_nx = FULL_HOLD;
                end else begin
                    w_idle_nx = w_idle_inc;
                    if (w_idle_inc == L_IMAX && r_vol != '0) begin
                        w_state_nx = DRAIN;
                        w_idle_nx  = '0;
                    end
                end
            end
            FULL_HOLD: begin
                w_state_nx = DRAIN;
                w_idle_nx  = '0;
            end
            DRAIN: begin
                if (r_vol == '0) begin
                    w_state_nx = EMPTY_HOLD;
                    w_idle_nx  = '0;
                end else if (w_st_valid) begin
                    w_st_gnt_nx = w_st_pick;
                    w_vol_nx    = r_vol - CBITS'(1);
                    w_st_ptr_nx = (w_st_idx == L_LAST) ? '0 : w_st_idx + IW'(1);
                    w_idle_nx   = '0;
                    if (r_vol == CBITS'(1)) w_state_nx = EMPTY_HOLD;
                end else begin
                    w_idle_nx = w_idle_inc;
                    if (w_idle_inc == L_IMAX && r_vol != L_CAP) begin
                        w_state_nx = FILL;
                        w_idle_nx  = '0;
                    end
                end
            end
            EMPTY_HOLD: begin
                w_state_nx = FILL;
                w_idle_nx  = '0;
            end
            default: begin
                w_state_nx = FILL;
                w_idle_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= FILL;
            r_vol    <= '0;
            r_ld_gnt <= '0;
            r_st_gnt <= '0;
            r_sig    <= 1'b0;
            r_ld_ptr <= '0;
            r_st_ptr <= '0;
            r_idle   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_vol    <= w_vol_nx;
            r_ld_gnt <= w_ld_gnt_nx;
            r_st_gnt <= w_st_gnt_nx;
            r_sig    <= w_sig_nx;
            r_ld_ptr <= w_ld_ptr_nx;
            r_st_ptr <= w_st_ptr_nx;
            r_idle   <= w_idle_nx;
        end
    end

    assign ld_gnt = r_ld_gnt;
    assign st_gnt = r_st_gnt;
    assign vol    = r_vol;
    assign sig    = r_sig;
    assign full   = (r_vol == L_CAP);
    assign empty  = (r_vol == '0);

endmodule

// File: tb/tb_vol_arbiter.sv
// Directed bench for vol_arbiter with N_REQ=4, CAP=10, IDLE_MAX=15.
// Each check packs {ld_gnt, st_gnt, vol, sig, full, empty} against hand-computed vectors.
module tb_vol_arbiter;
    import vol_arb_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] ld_req;
    logic [3:0] st_req;
    logic [3:0] ld_gnt;
    logic [3:0] st_gnt;
    logic [3:0] vol;
    logic       full;
    logic       empty;
    logic       sig;

    int unsigned tests  = 0;
    int unsigned errors = 0;
    logic [14:0] got;
    logic [14:0] exp;

    vol_arbiter #(.N_REQ(4), .CAP(10), .CBITS(4), .IDLE_MAX(15)) dut (
        .clk    (clk),
        .rst    (rst),
        .ld_req (ld_req),
        .st_req (st_req),
        .ld_gnt (ld_gnt),
        .st_gnt (st_gnt),
        .vol    (vol),
        .full   (full),
        .empty  (empty),
        .sig    (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(ld_gnt | st_gnt) && (ld_gnt == '0 || st_gnt == '0))
        else begin errors++; $display("FAIL a_onehot ld_gnt=%b st_gnt=%b", ld_gnt, st_gnt); end
    a_bound: assert property (@(posedge clk) disable iff (!rst) vol <= 4'd10)
        else begin errors++; $display("FAIL a_bound vol=%0d max 10", vol); end
    a_sig: assert property (@(posedge clk) disable iff (!rst) sig |=> !sig ##1 !sig)
        else begin errors++; $display("FAIL a_sig sig repeated within 2 cycles"); end
    a_ldfill: assert property (@(posedge clk) disable iff (!rst) (ld_gnt != '0) |-> ($past(dut.r_state) == FILL))
        else begin errors++; $display("FAIL a_ldfill ld_gnt=%b outside FILL", ld_gnt); end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; ld_req = 4'b1111; st_req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        exp = {4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL reset_state got=%b exp=%b", got, exp); end
        rst = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            got = {ld_gnt, st_gnt, vol, sig, full, empty};
            exp = {4'(1 << k), 4'b0000, 4'(k + 1), 1'b0, 1'b0, 1'b0};
            tests++;
            if (got !== exp) begin errors++; $display("FAIL reset_rr k=%0d got=%b exp=%b", k, got, exp); end
        end
    endtask

    task automatic test_fill_to_full;
        ld_req = 4'b0001;
        for (int unsigned k = 0; k < 6; k++) begin
            tick();
            got = {ld_gnt, st_gnt, vol, sig, full, empty};
            exp = {4'b0001, 4'b0000, 4'(5 + k), 1'b0, (5 + k == 10), 1'b0};
            tests++;
            if (got !== exp) begin errors++; $display("FAIL fill k=%0d got=%b exp=%b", k, got, exp); end
        end
        ld_req = 4'b0000;
        tick();
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        exp = {4'b0000, 4'b0000, 4'd10, 1'b1, 1'b1, 1'b0};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL full_sig got=%b exp=%b", got, exp); end
    endtask

    task automatic test_drain;
        st_req = 4'b1010; ld_req = 4'b1111;
        for (int unsigned k = 0; k < 10; k++) begin
            tick();
            got = {ld_gnt, st_gnt, vol, sig, full, empty};
            exp = {4'b0000, (k % 2 == 0) ? 4'b0010 : 4'b1000, 4'(9 - k), 1'b0, 1'b0, (k == 9)};
            tests++;
            if (got !== exp) begin errors++; $display("FAIL drain k=%0d got=%b exp=%b", k, got, exp); end
        end
        st_req = 4'b1111;
        tick();
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        exp = {4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL empty_hold got=%b exp=%b", got, exp); end
    endtask

    task automatic test_both_reqs;
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            got = {ld_gnt, st_gnt, vol, sig, full, empty};
            exp = {4'(1 << ((1 + k) % 4)), 4'b0000, 4'(k + 1), 1'b0, 1'b0, 1'b0};
            tests++;
            if (got !== exp) begin errors++; $display("FAIL both_reqs k=%0d got=%b exp=%b", k, got, exp); end
        end
    endtask

    task automatic test_idle_switch;
        ld_req = 4'b0000; st_req = 4'b0001;
        for (int unsigned k = 1; k <= 15; k++) begin
            tick();
            got = {ld_gnt, st_gnt, vol, sig, full, empty};
            exp = {4'b0000, 4'b0000, 4'd5, 1'b0, 1'b0, 1'b0};
            tests++;
            if (got !== exp) begin errors++; $display("FAIL fill_idle k=%0d got=%b exp=%b", k, got, exp); end
        end
        tick();
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        exp = {4'b0000, 4'b0001, 4'd4, 1'b0, 1'b0, 1'b0};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL fill_timeout got=%b exp=%b", got, exp); end
    endtask

    task automatic test_drain_idle;
        st_req = 4'b0000; ld_req = 4'b0001;
        for (int unsigned k = 1; k <= 15; k++) begin
            tick();
            got = {ld_gnt, st_gnt, vol, sig, full, empty};
            exp = {4'b0000, 4'b0000, 4'd4, 1'b0, 1'b0, 1'b0};
            tests++;
            if (got !== exp) begin errors++; $display("FAIL drain_idle k=%0d got=%b exp=%b", k, got, exp); end
        end
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            got = {ld_gnt, st_gnt, vol, sig, full, empty};
            exp = {4'b0001, 4'b0000, 4'(5 + k), 1'b0, 1'b0, 1'b0};
            tests++;
            if (got !== exp) begin errors++; $display("FAIL refill k=%0d got=%b exp=%b", k, got, exp); end
        end
    endtask

    task automatic test_reset_mid;
        #2;
        rst = 1'b0;
        #1;
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        exp = {4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL async_reset got=%b exp=%b", got, exp); end
        tick();
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL reset_hold got=%b exp=%b", got, exp); end
        rst = 1'b1; ld_req = 4'b0000;
        tick();
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL post_reset_idle got=%b exp=%b", got, exp); end
        ld_req = 4'b1111;
        tick();
        got = {ld_gnt, st_gnt, vol, sig, full, empty};
        exp = {4'b0001, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0};
        tests++;
        if (got !== exp) begin errors++; $display("FAIL post_reset_ptr got=%b exp=%b", got, exp); end
    endtask

    initial begin
        rst = 1'b0; ld_req = '0; st_req = '0;
        test_reset();
        test_fill_to_full();
        test_drain();
        test_both_reqs();
        test_idle_switch();
        test_drain_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
